// File: rtl/seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl
//   Time-multiplexing scan controller for a 4-digit seven-segment display.
//   Holds a 16-bit display word and walks the digit decoder's select/nibble
//   inputs through digits 0..3, one digit slot every TICK_DIV clocks. The first
//   BLANK_CYCLES clocks of every slot are blanked to suppress ghosting while
//   the anode select settles. New words are committed only at a frame boundary
//   so a frame never shows a mix of old and new digits.
//
// Ports
//   clk         in   1   system clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   disp_en     in   1   1 = scan active, 0 = display dark (registered)
//   lzb_en      in   1   1 = blank leading zero digits (registered)
//   digit_mask  in   4   bit i = 1 forces digit i dark (registered)
//   load        in   1   strobe: data_in -> pending register
//   data_in     in   16  [3:0] = digit0 (rightmost) .. [15:12] = digit3
//   dec_en      out  2   digit select to decoder, 0 = rightmost anode
//   dec_num     out  4   nibble of the selected digit
//   blank       out  1   1 = force all anodes off
//   frame_tick  out  1   1-cycle pulse after the digit 3 slot ends
//   upd_ack     out  1   1-cycle pulse after the pending word is committed
// ---------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        disp_en,
  input  logic        lzb_en,
  input  logic [3:0]  digit_mask,
  input  logic        load,
  input  logic [15:0] data_in,
  output logic [1:0]  dec_en,
  output logic [3:0]  dec_num,
  output logic        blank,
  output logic        frame_tick,
  output logic        upd_ack
);

  localparam logic [CNT_W-1:0] PRESC_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LIMIT = CNT_W'(BLANK_CYCLES);

  typedef enum logic {
    S_GUARD = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  // Registered state
  state_t             state_q,      state_d;
  logic [CNT_W-1:0]   presc_q,      presc_d;
  logic [1:0]         dec_en_q,     dec_en_d;
  logic [15:0]        display_q,    display_d;
  logic [15:0]        pending_q,    pending_d;
  logic               pend_vld_q,   pend_vld_d;
  logic               frame_tick_q, frame_tick_d;
  logic               upd_ack_q,    upd_ack_d;
  logic               disp_en_q,    disp_en_d;
  logic               lzb_en_q,     lzb_en_d;
  logic [3:0]         mask_q,       mask_d;

  // Decoded control
  logic               slot_end;
  logic               frame_end;
  logic               commit;
  logic [3:0]         upper_zero;
  logic               lz_blank;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    disp_en_d = disp_en;
    lzb_en_d  = lzb_en;
    mask_d    = digit_mask;

    slot_end  = disp_en_q && (presc_q == PRESC_LAST);
    frame_end = slot_end && (dec_en_q == 2'd3);
    // While dark there is no frame to tear, so commit as soon as possible.
    commit    = pend_vld_q && (frame_end || !disp_en_q);

    presc_d  = presc_q;
    dec_en_d = dec_en_q;
    if (!disp_en_q) begin
      presc_d  = '0;
      dec_en_d = '0;
    end else if (slot_end) begin
      presc_d  = '0;
      dec_en_d = dec_en_q + 2'd1;
    end else begin
      presc_d  = presc_q + 1'b1;
    end

    // State follows the prescaler value it will hold next, so GUARD always
    // coincides exactly with prescaler < BLANK_CYCLES.
    state_d = state_q;
    if (!disp_en_q) begin
      state_d = S_GUARD;
    end else begin
      case (state_q)
        S_GUARD: if (presc_d >= GUARD_LIMIT) state_d = S_SHOW;
        S_SHOW:  if (presc_d <  GUARD_LIMIT) state_d = S_GUARD;
        default: state_d = S_GUARD;
      endcase
    end

    // Load and commit in the same cycle: old pending goes to display, new
    // data stays pending.
    display_d  = commit ? pending_q : display_q;
    pending_d  = load ? data_in : pending_q;
    pend_vld_d = pend_vld_q;
    if (load) begin
      pend_vld_d = 1'b1;
    end else if (commit) begin
      pend_vld_d = 1'b0;
    end

    frame_tick_d = frame_end;
    upd_ack_d    = commit;
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_GUARD;
      presc_q      <= '0;
      dec_en_q     <= '0;
      display_q    <= '0;
      pending_q    <= '0;
      pend_vld_q   <= 1'b0;
      frame_tick_q <= 1'b0;
      upd_ack_q    <= 1'b0;
      disp_en_q    <= 1'b0;
      lzb_en_q     <= 1'b0;
      mask_q       <= '0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      dec_en_q     <= dec_en_d;
      display_q    <= display_d;
      pending_q    <= pending_d;
      pend_vld_q   <= pend_vld_d;
      frame_tick_q <= frame_tick_d;
      upd_ack_q    <= upd_ack_d;
      disp_en_q    <= disp_en_d;
      lzb_en_q     <= lzb_en_d;
      mask_q       <= mask_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (registers only, no input-to-output path)
  // -------------------------------------------------------------------------
  // upper_zero[i] = digit i and every digit above it are zero.
  always_comb begin
    upper_zero[3] = (display_q[15:12] == 4'h0);
    upper_zero[2] = upper_zero[3] && (display_q[11:8] == 4'h0);
    upper_zero[1] = upper_zero[2] && (display_q[7:4]  == 4'h0);
    upper_zero[0] = upper_zero[1] && (display_q[3:0]  == 4'h0);
    // Digit 0 always shows, even when the whole word is zero.
    lz_blank      = lzb_en_q && (dec_en_q != 2'd0) && upper_zero[dec_en_q];
  end

  assign dec_en     = dec_en_q;
  assign dec_num    = display_q[{dec_en_q, 2'b00} +: 4];
  assign blank      = (state_q == S_GUARD) || !disp_en_q || mask_q[dec_en_q] || lz_blank;
  assign frame_tick = frame_tick_q;
  assign upd_ack    = upd_ack_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_ctrl
//   Directed bench for seven_seg_scan_ctrl with TICK_DIV=8, BLANK_CYCLES=2.
//   Expected per-cycle outputs of whole frames are queued up front from the
//   intended display words and popped one per clock while the scan runs.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        disp_en = 1'b0;
  logic        lzb_en = 1'b0;
  logic [3:0]  digit_mask = '0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [1:0]  dec_en;
  logic [3:0]  dec_num;
  logic        blank;
  logic        frame_tick;
  logic        upd_ack;

  seven_seg_scan_ctrl #(
    .TICK_DIV    (8),
    .BLANK_CYCLES(2),
    .CNT_W       (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .disp_en   (disp_en),
    .lzb_en    (lzb_en),
    .digit_mask(digit_mask),
    .load      (load),
    .data_in   (data_in),
    .dec_en    (dec_en),
    .dec_num   (dec_num),
    .blank     (blank),
    .frame_tick(frame_tick),
    .upd_ack   (upd_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] en;
    logic [3:0] num;
    logic       blk;
    logic       ft;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];
  int   n_asserts = 0;
  int   n_fail    = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One frame = 4 slots x 8 clocks, starting at digit 0, prescaler 0.
  task automatic push_frame(input logic [15:0] w, input logic [3:0] msk,
                            input bit lzb, input bit ft0, input bit ack0);
    exp_t        e;
    int          d;
    int          ph;
    logic [15:0] hi;
    for (int j = 0; j < 32; j++) begin
      d     = j / 8;
      ph    = j % 8;
      hi    = w >> (4 * d);
      e.en  = 2'(d);
      e.num = hi[3:0];
      e.blk = (ph < 2) || msk[d] || (lzb && (d > 0) && (hi == 16'h0));
      e.ft  = (j == 0) && ft0;
      e.ack = (j == 0) && ack0;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_n(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      cyc();
      if (exp_q.size() == 0) begin
        n_asserts++;
        n_fail++;
        $error("FAIL sb_underrun: observed empty queue, required an entry");
      end else begin
        e = exp_q.pop_front();
        chk("sb_dec_en",     16'(dec_en),     16'(e.en));
        chk("sb_dec_num",    16'(dec_num),    16'(e.num));
        chk("sb_blank",      16'(blank),      16'(e.blk));
        chk("sb_frame_tick", 16'(frame_tick), 16'(e.ft));
        chk("sb_upd_ack",    16'(upd_ack),    16'(e.ack));
      end
    end
  endtask

  task automatic load_step(input logic [15:0] d);
    load    = 1'b1;
    data_in = d;
    run_n(1);
    load    = 1'b0;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    cyc();
    cyc();
    chk("rst_dec_en",     16'(dec_en),     16'h0);
    chk("rst_dec_num",    16'(dec_num),    16'h0);
    chk("rst_blank",      16'(blank),      16'h1);
    chk("rst_frame_tick", 16'(frame_tick), 16'h0);
    chk("rst_upd_ack",    16'(upd_ack),    16'h0);
    rst_n = 1'b1;
    cyc();
    chk("dark_blank", 16'(blank), 16'h1);

    // Display dark: load commits on the following clock
    load    = 1'b1;
    data_in = 16'h1234;
    cyc();
    load    = 1'b0;
    chk("dark_ack_early", 16'(upd_ack), 16'h0);
    chk("dark_num_old",   16'(dec_num), 16'h0);
    cyc();
    chk("dark_ack",    16'(upd_ack), 16'h1);
    chk("dark_num",    16'(dec_num), 16'h4);
    chk("dark_blank2", 16'(blank),   16'h1);
    chk("dark_dec_en", 16'(dec_en),  16'h0);
    cyc();
    chk("dark_ack_end", 16'(upd_ack), 16'h0);

    // Scan frames A..H
    push_frame(16'h1234, 4'b0000, 1'b0, 1'b0, 1'b0);
    push_frame(16'hABCD, 4'b0000, 1'b0, 1'b1, 1'b1);
    push_frame(16'hABCD, 4'b0000, 1'b0, 1'b1, 1'b0);
    push_frame(16'h2222, 4'b0000, 1'b0, 1'b1, 1'b1);
    push_frame(16'h3333, 4'b0000, 1'b0, 1'b1, 1'b1);
    push_frame(16'h0050, 4'b0000, 1'b1, 1'b1, 1'b1);
    push_frame(16'h0000, 4'b0000, 1'b1, 1'b1, 1'b1);
    push_frame(16'h5678, 4'b0100, 1'b0, 1'b1, 1'b1);
    disp_en = 1'b1;
    // A: tear-free load during digit 1
    run_n(9);
    load_step(16'hABCD);
    run_n(22);
    // B
    run_n(32);
    // C: two loads, last wins
    run_n(5);
    load_step(16'h1111);
    run_n(14);
    load_step(16'h2222);
    run_n(11);
    // D: load on the commit edge
    load_step(16'h3333);
    run_n(31);
    // E: enable leading-zero blanking, load 0x0050
    run_n(10);
    lzb_en = 1'b1;
    load_step(16'h0050);
    run_n(21);
    // F
    run_n(3);
    load_step(16'h0000);
    run_n(28);
    // G
    run_n(3);
    load_step(16'h5678);
    run_n(28);
    // H: mask digit 2
    lzb_en     = 1'b0;
    digit_mask = 4'b0100;
    run_n(32);

    // Disable mid-stream
    disp_en    = 1'b0;
    digit_mask = 4'b0000;
    cyc();
    chk("dis_dec_en",     16'(dec_en),     16'h0);
    chk("dis_blank",      16'(blank),      16'h1);
    chk("dis_frame_tick", 16'(frame_tick), 16'h1);
    chk("dis_upd_ack",    16'(upd_ack),    16'h0);
    cyc();
    chk("dis_dec_en2",    16'(dec_en),     16'h0);
    chk("dis_blank2",     16'(blank),      16'h1);
    chk("dis_frame_tick2",16'(frame_tick), 16'h0);
    chk("dis_dec_num",    16'(dec_num),    16'h8);
    load    = 1'b1;
    data_in = 16'h9ABC;
    cyc();
    load    = 1'b0;
    chk("dis_ack_early", 16'(upd_ack), 16'h0);
    cyc();
    chk("dis_ack",     16'(upd_ack), 16'h1);
    chk("dis_num_new", 16'(dec_num), 16'hC);
    cyc();
    chk("dis_ack_end", 16'(upd_ack), 16'h0);

    // Re-enable, then reset mid-slot with a word pending
    push_frame(16'h9ABC, 4'b0000, 1'b0, 1'b0, 1'b0);
    disp_en = 1'b1;
    run_n(5);
    load_step(16'h7777);
    run_n(6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dec_en",     16'(dec_en),     16'h0);
    chk("mid_rst_dec_num",    16'(dec_num),    16'h0);
    chk("mid_rst_blank",      16'(blank),      16'h1);
    chk("mid_rst_frame_tick", 16'(frame_tick), 16'h0);
    chk("mid_rst_upd_ack",    16'(upd_ack),    16'h0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    // Pending 0x7777 is lost: two frames of zero, no upd_ack anywhere
    push_frame(16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    push_frame(16'h0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    run_n(64);
    chk("sb_drained", 16'(exp_q.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
